// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word fall-through FIFO.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst_n       synchronous active-low reset
//   rx_i        asynchronous serial line, idle high
//   rd_en_i     pop the FIFO head this cycle
//   clr_i       clear the sticky overflow flag
//   data_o      FIFO head byte (8'h00 while empty)
//   valid_o     FIFO not empty
//   count_o     FIFO occupancy, 0..FIFO_DEPTH
//   frame_err_o one-cycle pulse when the stop bit samples low
//   overflow_o  sticky: a received byte was dropped because the FIFO was full
//   state_o     receiver state (IDLE=0 START=1 DATA=2 STOP=3 WAIT_IDLE=4)
//
// Read handshake: valid_o acts as "valid" and rd_en_i as "ready". A pop
// happens on a rising edge only when both are high. rd_en_i with valid_o low
// is ignored. data_o presents the next entry on the cycle after a pop.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 256,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rd_en_i,
  input  logic                          clr_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [2:0]                    state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // ---------------- synchronizer and start-edge detect ----------------
  logic       rx_meta, rx_s, rx_prev;
  logic [2:0] sync_vld;
  logic       start_edge;

  // The flops reset high (idle line). sync_vld marks which stages hold real
  // line samples rather than reset values. An edge counts only once both
  // rx_s and rx_prev are real, so a line that is already low at reset
  // release is not mistaken for a new start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= 3'b000;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  assign start_edge = sync_vld[2] & rx_prev & ~rx_s;

  // ---------------- receiver FSM ----------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            bit_tick;
  logic            push;

  assign bit_tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_edge) state_d = S_START;
      S_START:     if (bit_tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (bit_tick && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:      if (bit_tick) state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push        = (state_q == S_STOP) && bit_tick && rx_s;
    frame_err_o = (state_q == S_STOP) && bit_tick && !rx_s;
    state_o     = state_q;
  end

  // Bit timer counts down to zero; expiry marks a sampling point. The first
  // load is half a bit so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: if (start_edge) cnt_q <= HALF_LOAD;
        S_START: begin
          if (bit_tick) begin
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= 3'd0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shift_q   <= {rx_s, shift_q[7:1]};  // LSB arrives first
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= BIT_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_STOP: if (!bit_tick) cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          full, pop, wr_en, ovf_set;

  assign full    = (count_q == DEPTH_CNT);
  assign pop     = rd_en_i && (count_q != '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)    overflow_o <= 1'b1;  // a new loss beats a clear
      else if (clr_i) overflow_o <= 1'b0;
    end
  end

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with CLKS_PER_BIT=16,
// FIFO_DEPTH=4. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, rx_i, rd_en_i, clr_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic [2:0] count_o;
  logic       frame_err_o, overflow_o;
  logic [2:0] state_o;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .rd_en_i(rd_en_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fe_count = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (frame_err_o) fe_count++;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at the current falling edge. pop_at and
  // clr_at pulse rd_en_i / clr_i during that frame cycle (-1 = never).
  // rise returns the frame cycle at which valid_o was first seen high.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int pop_at, input int clr_at, output int rise);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    rise = -1;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i % CPB == 0) rx_i = bits[i / CPB];
      rd_en_i = (i == pop_at);
      clr_i   = (i == clr_at);
      @(negedge clk);
      if (rise < 0 && valid_o) rise = i + 1;
    end
    rd_en_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int r;
    send_frame(b, 1'b1, -1, -1, r);
    tick(4);
  endtask

  task automatic pop_expect(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, " valid"}, valid_o, 1);
    check({tag, " data"}, data_o, e);
    rd_en_i = 1'b1;
    tick(1);
    rd_en_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rise;
    int fe0;
    rst_n = 1'b0; rx_i = 1'b1; rd_en_i = 1'b0; clr_i = 1'b0;
    tick(4);
    check("reset valid", valid_o, 0);
    check("reset count", count_o, 0);
    check("reset data", data_o, 8'h00);
    check("reset frame_err", frame_err_o, 0);
    check("reset overflow", overflow_o, 0);
    check("reset state", state_o, 0);
    rst_n = 1'b1;
    tick(4);

    // Byte 0x65: start detected 3 cycles in, half bit + 9 bits later the
    // stop sample lands on edge 155; valid_o shows it from that cycle.
    send_frame(8'h65, 1'b1, -1, -1, rise);
    check("rx65 latency", rise, 155);
    tick(4);
    check("rx65 count", count_o, 1);
    check("rx65 frame_err", fe_count, 0);
    exp_q.push_back(8'h65);
    pop_expect("rx65");
    check("rx65 empty", count_o, 0);

    // 5-cycle glitch must be rejected at the mid-start check.
    rx_i = 1'b0; tick(5);
    rx_i = 1'b1; tick(30);
    check("glitch state", state_o, 0);
    check("glitch count", count_o, 0);
    check("glitch frame_err", fe_count, 0);
    send_byte(8'hA5);
    check("rxA5 count", count_o, 1);
    exp_q.push_back(8'hA5);
    pop_expect("rxA5");

    // Bad stop bit followed by a 40-cycle break: exactly one error pulse.
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, -1, -1, rise);
    tick(40);
    check("break state", state_o, 4);
    rx_i = 1'b1;
    tick(20);
    check("break frame_err pulses", fe_count - fe0, 1);
    check("break count", count_o, 0);
    check("break state idle", state_o, 0);
    send_byte(8'h38);
    check("rx38 count", count_o, 1);
    exp_q.push_back(8'h38);
    pop_expect("rx38");

    // Overflow: 5 bytes into 4 entries. The clear lands on the push cycle of
    // the dropped byte, so the flag must still be set afterwards.
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    check("fill count", count_o, 4);
    check("fill overflow", overflow_o, 0);
    send_frame(8'h05, 1'b1, -1, 154, rise);
    tick(4);
    check("ovf set wins", overflow_o, 1);
    check("ovf count", count_o, 4);
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    for (int b = 1; b <= 4; b++) pop_expect("ovf pop");
    check("ovf drained", count_o, 0);
    check("empty data", data_o, 8'h00);
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    check("ovf cleared", overflow_o, 0);

    // Full FIFO with a pop on the push cycle of 0x77.
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("full count", count_o, 4);
    send_frame(8'h77, 1'b1, 154, -1, rise);
    tick(4);
    check("push+pop overflow", overflow_o, 0);
    check("push+pop count", count_o, 4);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h77);
    for (int k = 0; k < 4; k++) pop_expect("push+pop");
    check("push+pop drained", count_o, 0);

    // Reset during bit 4 (low) of 0x0F; the line is still low at release.
    fe0 = fe_count;
    rx_i = 1'b0; tick(CPB);
    rx_i = 1'b1; tick(4 * CPB);
    rx_i = 1'b0; tick(6);
    rst_n = 1'b0; tick(3);
    check("midframe reset state", state_o, 0);
    rst_n = 1'b1;
    tick(10);
    check("low at release state", state_o, 0);
    rx_i = 1'b1;
    tick(40);
    check("abort count", count_o, 0);
    check("abort frame_err", fe_count - fe0, 0);
    send_byte(8'hC3);
    check("rxC3 count", count_o, 1);
    exp_q.push_back(8'hC3);
    pop_expect("rxC3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 256, clk cycles per UART bit (200 MHz / 781250 baud); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_i  input  1  serial line from the DUT uart_tx; idle high; asynchronous to clk.
REQ-006 SHALL have port rd_en_i  input  1  pop the FIFO head this cycle.
REQ-007 SHALL have port clr_i  input  1  clear the sticky overflow_o flag.
REQ-008 SHALL have port data_o  output  8  FIFO head byte, first-word fall-through.
REQ-009 SHALL have port valid_o  output  1  FIFO not empty; data_o is meaningful.
REQ-010 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overflow_o  output  1  sticky; a byte was lost because the FIFO was full.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all receiver logic SHALL use the synchronized value rx_s.
REQ-014 SHALL implement receiver states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: SHALL move to START on a 1->0 transition of rx_s and load the bit counter with CLKS_PER_BIT/2-1.
REQ-016 START: at counter expiry (mid start bit) SHALL go to DATA if rx_s=0; otherwise SHALL treat it as a glitch and return to IDLE with no output.
REQ-017 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles, LSB first, into an 8-bit shift register, and SHALL go to STOP after the 8th sample.
REQ-018 STOP: SHALL sample rx_s once CLKS_PER_BIT cycles after the 8th data sample. If it is 1, SHALL push the byte and go to IDLE. If it is 0, SHALL discard the byte, pulse frame_err_o for one cycle, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL stay until rx_s=1, then go to IDLE; a line held low (break) SHALL produce exactly one frame_err_o pulse.
REQ-020 Push latency: valid_o/count_o SHALL reflect the new byte on the cycle after the stop-bit sample cycle.
REQ-021 Pop: rd_en_i with valid_o=1 SHALL advance the head; data_o SHALL show the next entry on the following cycle. rd_en_i with valid_o=0 SHALL be ignored.
REQ-022 Push when full with no pop in the same cycle: SHALL drop the byte, leave the FIFO contents unchanged, and set overflow_o.
REQ-023 Push and pop in the same cycle: both SHALL succeed, including when full (no overflow) and when count=1; count_o SHALL stay unchanged.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; count_o SHALL range 0..FIFO_DEPTH.
REQ-025 overflow_o SHALL clear on clr_i. If clr_i coincides with a new overflow event, set SHALL win.
REQ-026 The bit counter width SHALL be $clog2(CLKS_PER_BIT); counter arithmetic SHALL not wrap within a bit period.

Reset
REQ-027 While rst_n=0 at a clk edge: state SHALL be IDLE, FIFO empty, valid_o=0, count_o=0, data_o=8'h00, frame_err_o=0, overflow_o=0.
REQ-028 Synchronizer flops SHALL reset to 1 so that a low rx_i at release does not register as a false start edge.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no push and no frame_err_o; after release, reception SHALL restart only on a new falling edge.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-030 Send 8N1 byte 8'h65 -> valid_o=1 and data_o=8'h65 one cycle after the stop sample; count_o=1; frame_err_o stays 0.
REQ-031 Drive a 5-cycle low glitch on rx_i -> no push, no frame_err_o, state back to IDLE; a following byte 8'hA5 is received correctly.
REQ-032 Send byte 8'h3C with stop bit=0, then hold the line low for 40 cycles -> one frame_err_o pulse, no push, next byte 8'h38 is received.
REQ-033 Send 5 bytes 8'h01..8'h05 with no reads -> count_o=4, overflow_o=1, pops return 01,02,03,04; clr_i clears overflow_o.
REQ-034 FIFO full, rd_en_i asserted on the push cycle of byte 8'h77 -> overflow_o stays 0, count_o stays 4, 8'h77 is the last byte popped.
REQ-035 Assert rst_n=0 during bit 4 of a byte -> after release, no push and no frame_err_o; the next full byte 8'hC3 is received.
